// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// serial_adder_if : operand/result bundle for serial_adder.   Rev 1.0
// ============================================================================
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, cin,
    input  sum, cout, busy, done
  );

  modport slave (
    input  start, a, b, cin,
    output sum, cout, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// serial_adder : bit-serial LSB-first adder, one full-adder cell.   Rev 1.0
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  wire logic     clk,
  input  wire logic     rst,
  serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  always_comb begin
    fa_s     = a_sr[0] ^ b_sr[0] ^ carry;
    fa_c     = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sum fills from the MSB end so the LSB lands in bit 0 after WIDTH shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            carry  <= bus.cin;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
          end
        end
        SHIFT: begin
          sum_r <= {fa_s, sum_r[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_c;
          cnt   <= cnt + 1'b1;
          if (last_bit) cout_r <= fa_c;
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// tb_serial_adder : directed self-checking bench for serial_adder.   Rev 1.0
// ============================================================================
module tb_serial_adder;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one 8-bit addition, scrambles the inputs after acceptance, waits for done.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      output logic [7:0] s, output logic co,
                      output int lat, output int nbusy);
    bus8.a = av; bus8.b = bv; bus8.cin = cv; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0; bus8.a = ~av; bus8.b = av ^ bv; bus8.cin = ~cv;
    lat = 0; nbusy = 0;
    while (bus8.done !== 1'b1 && lat < 20) begin
      if (bus8.busy === 1'b1) nbusy++;
      tick();
      lat++;
    end
    s = bus8.sum; co = bus8.cout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (bus8.sum !== 8'h00) begin n_err++; $display("FAIL reset_sum: got %h want 00", bus8.sum); end
    n_cmp++; if (bus8.cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b want 0", bus8.cout); end
    n_cmp++; if (bus8.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus8.busy); end
    n_cmp++; if (bus8.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus8.done); end
    tick();
    n_cmp++; if (bus8.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", bus8.busy); end
  endtask

  task automatic test_basic();
    logic [7:0] s; logic co; int lat; int nb;
    run8(8'h5A, 8'h33, 1'b0, s, co, lat, nb);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL basic_latency: got %0d want 8", lat); end
    n_cmp++; if (nb !== 8) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 8", nb); end
    n_cmp++; if (s !== 8'h8D) begin n_err++; $display("FAIL basic_sum: got %h want 8d", s); end
    n_cmp++; if (co !== 1'b0) begin n_err++; $display("FAIL basic_cout: got %b want 0", co); end
    n_cmp++; if (bus8.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_in_done: got %b want 0", bus8.busy); end
    tick();
    n_cmp++; if (bus8.done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", bus8.done); end
    n_cmp++; if (bus8.sum !== 8'h8D) begin n_err++; $display("FAIL basic_hold_sum: got %h want 8d", bus8.sum); end
    tick();
  endtask

  task automatic test_carry();
    logic [7:0] s; logic co; int lat; int nb;
    run8(8'hFF, 8'h01, 1'b0, s, co, lat, nb);
    n_cmp++; if ({co, s} !== 9'h100) begin n_err++; $display("FAIL carry_ff_01: got %h want 100", {co, s}); end
    tick(); tick();
    n_cmp++; if ({bus8.cout, bus8.sum} !== 9'h100) begin n_err++; $display("FAIL carry_hold_idle: got %h want 100", {bus8.cout, bus8.sum}); end
    run8(8'hFF, 8'hFF, 1'b1, s, co, lat, nb);
    n_cmp++; if ({co, s} !== 9'h1FF) begin n_err++; $display("FAIL carry_all_ones: got %h want 1ff", {co, s}); end
    tick();
    run8(8'h00, 8'h00, 1'b0, s, co, lat, nb);
    n_cmp++; if ({co, s} !== 9'h000) begin n_err++; $display("FAIL carry_zero: got %h want 000", {co, s}); end
    tick();
    run8(8'hA5, 8'h5A, 1'b1, s, co, lat, nb);
    n_cmp++; if ({co, s} !== 9'h100) begin n_err++; $display("FAIL carry_ripple: got %h want 100", {co, s}); end
    tick();
  endtask

  task automatic test_start_ignored();
    int lat; int extra;
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick(); tick(); tick();
    bus8.a = 8'hAA; bus8.b = 8'hAA; bus8.cin = 1'b1; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    lat = 6;
    while (bus8.done !== 1'b1 && lat < 20) begin tick(); lat++; end
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL ignore_latency: got %0d want 8", lat); end
    n_cmp++; if ({bus8.cout, bus8.sum} !== 9'h046) begin n_err++; $display("FAIL ignore_sum: got %h want 046", {bus8.cout, bus8.sum}); end
    extra = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL ignore_extra_activity: got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s; logic co; int lat; int nb; int seen;
    bus8.a = 8'hFF; bus8.b = 8'h01; bus8.cin = 1'b1; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus8.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", bus8.busy); end
    n_cmp++; if (bus8.done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", bus8.done); end
    n_cmp++; if ({bus8.cout, bus8.sum} !== 9'h000) begin n_err++; $display("FAIL rstmid_result: got %h want 000", {bus8.cout, bus8.sum}); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus8.done === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d want 0", seen); end
    run8(8'h10, 8'h20, 1'b0, s, co, lat, nb);
    n_cmp++; if ({co, s} !== 9'h030) begin n_err++; $display("FAIL rstmid_fresh: got %h want 030", {co, s}); end
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL rstmid_latency: got %0d want 8", lat); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [8:0] idx;
    logic [4:0] exp_v;
    int gap;
    idx = 9'd0;
    bus4.a = idx[3:0]; bus4.b = idx[7:4]; bus4.cin = idx[8]; bus4.start = 1'b1;
    tick();
    for (int i = 0; i < 512; i++) begin
      idx   = 9'(i);
      exp_v = 5'(idx[3:0]) + 5'(idx[7:4]) + 5'(idx[8]);
      if (i < 511) begin
        idx = 9'(i + 1);
        bus4.a = idx[3:0]; bus4.b = idx[7:4]; bus4.cin = idx[8];
      end else begin
        bus4.start = 1'b0;
      end
      gap = 0;
      while (bus4.done !== 1'b1 && gap < 10) begin tick(); gap++; end
      n_cmp++; if (gap !== 4) begin n_err++; $display("FAIL b2b_latency case %0d: got %0d want 4", i, gap); end
      n_cmp++; if ({bus4.cout, bus4.sum} !== exp_v) begin n_err++; $display("FAIL b2b_sum case %0d: got %h want %h", i, {bus4.cout, bus4.sum}, exp_v); end
      tick();
      n_cmp++; if (bus4.done !== 1'b0) begin n_err++; $display("FAIL b2b_done_pulse case %0d: got %b want 0", i, bus4.done); end
      if (i < 511) begin
        tick();
        n_cmp++; if (bus4.busy !== 1'b1) begin n_err++; $display("FAIL b2b_reaccept case %0d: got %b want 1", i, bus4.busy); end
      end
    end
    tick();
    n_cmp++; if (bus4.busy !== 1'b0) begin n_err++; $display("FAIL b2b_final_idle: got %b want 0", bus4.busy); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_carry();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
